program_sequencer: RTL and testbench



---
 rtl/program_sequencer.sv | 143 ++++++++++++++
 tb/tb_program_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Byte-wide program store that streams a loaded program over a valid/ready link
// into the Microcontroller core's data_in; all outputs are registered.
module program_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic [7:0]    instr_out,
  output logic          out_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          load_err
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_instr, w_instr;
  logic          r_valid, w_valid;
  logic [AW-1:0] r_pc, w_pc;
  logic [AW:0]   r_len, w_len;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_load_err, w_load_err;
  logic          w_we;
  logic          w_xfer;
  logic          w_last;
  logic [AW-1:0] w_pc_inc;

  assign w_xfer   = r_valid && out_ready;
  assign w_last   = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));
  assign w_pc_inc = r_pc + AW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_instr     = r_instr;
    w_valid     = r_valid;
    w_pc        = r_pc;
    w_len       = r_len;
    w_done      = 1'b0;
    w_load_err  = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          // start wins over a same-cycle load; the write is dropped
          w_load_err = load_en;
          if (prog_len == '0) begin
            w_state_nxt = S_DONE;
            w_done      = 1'b1;
          end else begin
            w_len       = (prog_len > LP_DEPTH) ? LP_DEPTH : prog_len;
            w_pc        = '0;
            w_instr     = r_mem[0];
            w_valid     = 1'b1;
            w_state_nxt = S_RUN;
          end
        end else begin
          w_we = load_en;
        end
      end
      S_RUN: begin
        w_load_err = load_en;
        // abort beats a same-cycle transfer: that byte is not consumed
        if (abort) begin
          w_valid     = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
          if (w_last) begin
            w_valid     = 1'b0;
            w_state_nxt = S_DONE;
            w_done      = 1'b1;
          end else begin
            w_pc    = w_pc_inc;
            w_instr = r_mem[w_pc_inc];
          end
        end
      end
      S_DONE: begin
        w_we        = load_en;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_valid     = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_len      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_instr    <= w_instr;
      r_valid    <= w_valid;
      r_pc       <= w_pc;
      r_len      <= w_len;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_load_err <= w_load_err;
    end
  end

  // Store is deliberately not reset so programs survive reset.
  always_ff @(posedge clk) begin
    if (!reset && w_we) begin
      r_mem[load_addr] <= load_data;
    end
  end

  assign instr_out = r_instr;
  assign out_valid = r_valid;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign done      = r_done;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: expected bytes are queued at start and
// popped as the DUT transfers them; control outputs are checked per step.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [4:0] prog_len;
  logic       start;
  logic       abort;
  logic       out_ready;
  logic [7:0] instr_out;
  logic       out_valid;
  logic [3:0] pc;
  logic       busy;
  logic       done;
  logic       load_err;

  int errors = 0;
  int checks = 0;
  logic [7:0]  m_mem [16];
  logic [11:0] sb_q [$];

  program_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .prog_len  (prog_len),
    .start     (start),
    .abort     (abort),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .out_valid (out_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the presented byte against the scoreboard head before the edge,
  // pops it if it transfers, then advances one clock.
  task automatic step();
    @(negedge clk);
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("sb_instr", {24'd0, instr_out}, {24'd0, sb_q[0][7:0]});
        chk("sb_pc", {28'd0, pc}, {28'd0, sb_q[0][11:8]});
        if (out_ready && !abort && !reset) void'(sb_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic push_prog(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back({4'(i), m_mem[i]});
  endtask

  task automatic kick(input logic [4:0] len, input int n);
    push_prog(n);
    prog_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Full stream with out_ready high: exact done timing and queue drain.
  task automatic do_run(input logic [4:0] len, input int n);
    kick(len, n);
    if (n > 0) chk("run_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) step();
    chk("run_done", {31'd0, done}, 32'd1);
    chk("run_valid_low", {31'd0, out_valid}, 32'd0);
    chk("run_sb_empty", sb_q.size(), 32'd0);
    step();
    chk("run_done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr"}, {24'd0, instr_out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_pc"}, {28'd0, pc}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_load_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    step(); step();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Basic stream, then a load accepted in the DONE cycle.
    load(4'd0, 8'h0A); load(4'd1, 8'h19); load(4'd2, 8'h25); load(4'd3, 8'h3C);
    kick(5'd4, 4);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_pc0", {28'd0, pc}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_valid_low", {31'd0, out_valid}, 32'd0);
    chk("t1_sb_empty", sb_q.size(), 32'd0);
    load(4'd15, 8'hF5);
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_done_load_err", {31'd0, load_err}, 32'd0);

    // Backpressure: hold 0x19 for three cycles.
    kick(5'd4, 4);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_pc", {28'd0, pc}, 32'd1);
      chk("t2_hold_instr", {24'd0, instr_out}, 32'h19);
    end
    out_ready = 1'b1;
    step(); step(); step();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_sb_empty", sb_q.size(), 32'd0);
    step();

    // Load during RUN is rejected.
    kick(5'd4, 4);
    load_en = 1'b1; load_addr = 4'd2; load_data = 8'hFF;
    step();
    load_en = 1'b0;
    chk("t3_load_err", {31'd0, load_err}, 32'd1);
    step();
    chk("t3_load_err_pulse", {31'd0, load_err}, 32'd0);
    step(); step();
    chk("t3_done", {31'd0, done}, 32'd1);
    step();
    do_run(5'd4, 4);

    // start + load_en in IDLE: start wins, write dropped.
    load_en = 1'b1; load_addr = 4'd0; load_data = 8'h77;
    kick(5'd4, 4);
    load_en = 1'b0;
    chk("t3b_load_err", {31'd0, load_err}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk("t3b_done", {31'd0, done}, 32'd1);
    chk("t3b_load_err_pulse", {31'd0, load_err}, 32'd0);
    step();

    // Abort at pc=2 with ready high.
    kick(5'd4, 4);
    step(); step();
    chk("t4_pc2", {28'd0, pc}, 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_no_done", {31'd0, done}, 32'd0);
    sb_q.delete();
    step();
    chk("t4_no_done2", {31'd0, done}, 32'd0);
    do_run(5'd4, 4);

    // Zero length and clamped length.
    do_run(5'd0, 0);
    for (int i = 4; i < 15; i++) load(4'(i), 8'(8'h40 + i));
    do_run(5'd31, 16);

    // Reset mid-RUN; store survives.
    kick(5'd4, 4);
    step();
    reset = 1'b1;
    step();
    chk_reset_vals("t6");
    reset = 1'b0;
    sb_q.delete();
    step();
    chk("t6_no_done", {31'd0, done}, 32'd0);
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    do_run(5'd4, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
